// File: rtl/debounce_multi.sv
// debounce_multi: parametrised multi-channel debouncer with per-channel
// synchronizer, stability counter, debounced level and rise/fall pulses.
// Optional long-press detection is built when DEBOUNCE_MULTI_LONG_PRESS_EN
// is defined; otherwise long_press is tied low.
module debounce_multi #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned NDELAY      = 1000000,
  parameter int unsigned NBITS       = 20,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT        = 1'b0,
  parameter int unsigned NLONG       = 3000000,
  parameter int unsigned LBITS       = 22
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] din,
  output logic [NCH-1:0] dout,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic           any_change,
  output logic [NCH-1:0] long_press
);

  localparam logic [NBITS-1:0] DELAY_MAX = NBITS'(NDELAY);

  // Elaboration-time sanity checks on counter widths
  if (64'(NDELAY) >= (64'd1 << NBITS)) begin : g_nbits_too_small
    $error("debounce_multi: NBITS too small for NDELAY");
  end
  if (64'(NLONG) >= (64'd1 << LBITS)) begin : g_lbits_too_small
    $error("debounce_multi: LBITS too small for NLONG");
  end

  logic [NCH-1:0]            sync_q [SYNC_STAGES];
  logic [NCH-1:0]            s;
  logic [NCH-1:0]            cand_q, cand_d;
  logic [NCH-1:0][NBITS-1:0] count_q, count_d;
  logic [NCH-1:0]            dout_d, rise_d, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Input synchronizer chain, one flop per stage for every channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {NCH{INIT}};
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-channel stability tracking; a changed sample restarts the count
  always_comb begin
    cand_d  = cand_q;
    count_d = count_q;
    dout_d  = dout;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s[i] != cand_q[i]) begin
        cand_d[i]  = s[i];
        count_d[i] = '0;
      end else if (count_q[i] == DELAY_MAX) begin
        dout_d[i] = cand_q[i];
        rise_d[i] = cand_q[i] & ~dout[i];
        fall_d[i] = ~cand_q[i] & dout[i];
      end else begin
        count_d[i] = count_q[i] + NBITS'(1);
      end
    end
  end

  // Debounce state and registered edge pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q     <= {NCH{INIT}};
      count_q    <= '0;
      dout       <= {NCH{INIT}};
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      count_q    <= count_d;
      dout       <= dout_d;
      rise       <= rise_d;
      fall       <= fall_d;
      any_change <= |(rise | fall);
    end
  end

`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
  localparam logic [LBITS-1:0] LONG_MAX = LBITS'(NLONG);

  logic [NCH-1:0][LBITS-1:0] lcnt_q, lcnt_d;
  logic [NCH-1:0]            long_d;

  // Hold-time counter per channel; pulse once when it reaches the threshold
  always_comb begin
    lcnt_d = lcnt_q;
    long_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!dout[i]) begin
        lcnt_d[i] = '0;
      end else if (lcnt_q[i] != LONG_MAX) begin
        lcnt_d[i] = lcnt_q[i] + LBITS'(1);
        long_d[i] = (lcnt_q[i] == LONG_MAX - LBITS'(1));
      end
    end
  end

  // Long-press counters and pulse register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcnt_q     <= '0;
      long_press <= '0;
    end else begin
      lcnt_q     <= lcnt_d;
      long_press <= long_d;
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed scenarios plus random toggling, checked against
// a sliding-window reference model of the debouncer.
module tb_debounce_multi;

  localparam int unsigned NCH         = 4;
  localparam int unsigned NDELAY      = 4;
  localparam int unsigned NBITS       = 3;
  localparam int unsigned SYNC_STAGES = 2;
  localparam logic        INIT        = 1'b0;
  localparam int unsigned NLONG       = 10;
  localparam int unsigned LBITS       = 4;
  // A level reaches dout once NDELAY+2 consecutive samples agree, seen
  // through SYNC_STAGES cycles of synchronizer delay.
  localparam int unsigned WIN  = NDELAY + 2;
  localparam int unsigned HIST = SYNC_STAGES + WIN;

  logic           clk;
  logic           reset_n;
  logic [NCH-1:0] din;
  logic [NCH-1:0] dout, rise, fall, long_press;
  logic           any_change;

  debounce_multi #(
    .NCH(NCH), .NDELAY(NDELAY), .NBITS(NBITS), .SYNC_STAGES(SYNC_STAGES),
    .INIT(INIT), .NLONG(NLONG), .LBITS(LBITS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .dout(dout), .rise(rise),
    .fall(fall), .any_change(any_change), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model state
  logic           hist [NCH][HIST];
  logic [NCH-1:0] m_dout, m_rise, m_fall, m_long;
  logic           m_any;
  int             rise_edge [NCH];

  // Observed pulse timing for directed checks
  int             obs_rise [NCH];
  int             obs_fall [NCH];
  int             obs_long [NCH];
  int             n_rise [NCH];
  int             n_fall [NCH];
  int             n_long [NCH];
  logic [NCH-1:0] first_rise_vec;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      for (int k = 0; k < HIST; k++) hist[i][k] = INIT;
      rise_edge[i] = -1;
    end
    m_dout = {NCH{INIT}};
    m_rise = '0;
    m_fall = '0;
    m_long = '0;
    m_any  = 1'b0;
  endtask

  // Advance the model by one clock edge using the din value just sampled
  task automatic model_edge();
    logic           v;
    bit             same;
    logic [NCH-1:0] prev_pulse;
    prev_pulse = m_rise | m_fall;
    for (int i = 0; i < NCH; i++) begin
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
      m_long[i] = m_dout[i] && (rise_edge[i] >= 0) && (cycle - rise_edge[i] == int'(NLONG));
`else
      m_long[i] = 1'b0;
`endif
      for (int k = HIST - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = din[i];
      v    = hist[i][SYNC_STAGES];
      same = 1'b1;
      for (int k = SYNC_STAGES; k < HIST; k++) if (hist[i][k] != v) same = 1'b0;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (same && (v != m_dout[i])) begin
        m_rise[i] = v;
        m_fall[i] = ~v;
        m_dout[i] = v;
        if (v) rise_edge[i] = cycle;
      end
    end
    m_any = |prev_pulse;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < NCH; i++) begin
      obs_rise[i] = -1; obs_fall[i] = -1; obs_long[i] = -1;
      n_rise[i] = 0; n_fall[i] = 0; n_long[i] = 0;
    end
    first_rise_vec = '0;
  endtask

  // Called at a negedge: drive din, clock once, compare, return at next negedge
  task automatic step(input logic [NCH-1:0] d);
    din = d;
    @(posedge clk);
    cycle++;
    model_edge();
    #1;
    check_eq("dout", 32'(dout), 32'(m_dout));
    check_eq("rise", 32'(rise), 32'(m_rise));
    check_eq("fall", 32'(fall), 32'(m_fall));
    check_eq("any_change", 32'(any_change), 32'(m_any));
    check_eq("long_press", 32'(long_press), 32'(m_long));
    if (|rise && first_rise_vec == '0) first_rise_vec = rise;
    for (int i = 0; i < NCH; i++) begin
      if (rise[i])       begin obs_rise[i] = cycle; n_rise[i]++; end
      if (fall[i])       begin obs_fall[i] = cycle; n_fall[i]++; end
      if (long_press[i]) begin obs_long[i] = cycle; n_long[i]++; end
    end
    @(negedge clk);
  endtask

  task automatic steps(input logic [NCH-1:0] d, input int n);
    for (int c = 0; c < n; c++) step(d);
  endtask

  // Called at a negedge: assert reset, verify async clear, release later
  task automatic pulse_reset(input int hold);
    reset_n = 1'b0;
    #1;
    check_eq("async_dout", 32'(dout), 32'(0));
    check_eq("async_pulses", 32'({rise, fall, long_press, any_change}), 32'(0));
    model_reset();
    repeat (hold) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int             samp;
  int             gap;
  int             hold_left [NCH];
  logic [NCH-1:0] rd;

  initial begin
    reset_n = 1'b0;
    din     = '0;
    model_reset();
    clear_obs();
    @(negedge clk);
    #1;
    check_eq("reset_dout", 32'(dout), 32'(0));
    check_eq("reset_pulses", 32'({rise, fall, long_press, any_change}), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single rise, latency SYNC_STAGES+NDELAY+1
    steps(4'b0000, 3);
    step(4'b0001);
    samp = cycle;
    steps(4'b0001, 10);
    check_eq("t1_latency", 32'(obs_rise[0] - samp), 32'(7));
    check_eq("t1_rise_count", 32'(n_rise[0]), 32'(1));
    check_eq("t1_no_fall", 32'(n_fall[0]), 32'(0));

    // 2: 3-cycle toggles on channel 1 never pass
    clear_obs();
    for (int c = 0; c < 40; c++) step({2'b00, ((c / 3) % 2 == 0), 1'b1});
    check_eq("t2_no_rise", 32'(n_rise[1]), 32'(0));
    check_eq("t2_no_fall", 32'(n_fall[1]), 32'(0));

    // 3: simultaneous rises on channels 0 and 3
    steps(4'b0000, 12);
    clear_obs();
    steps(4'b1001, 12);
    check_eq("t3_rise_vec", 32'(first_rise_vec), 32'(4'b1001));
    check_eq("t3_same_cycle", 32'(obs_rise[0] - obs_rise[3]), 32'(0));
    check_eq("t3_dout", 32'(dout), 32'(4'b1001));

    // 4: falling input with a 2-cycle glitch on channel 2
    steps(4'b1101, 12);
    clear_obs();
    steps(4'b1001, 2);
    steps(4'b1101, 2);
    step(4'b1001);
    samp = cycle;
    steps(4'b1001, 12);
    check_eq("t4_fall_latency", 32'(obs_fall[2] - samp), 32'(7));
    check_eq("t4_one_fall", 32'(n_fall[2]), 32'(1));
    check_eq("t4_no_rise", 32'(n_rise[2]), 32'(0));

    // 5: reset mid-count, then a fresh transition after release
    steps(4'b1000, 12);
    step(4'b1001);
    steps(4'b1001, 4);
    pulse_reset(2);
    clear_obs();
    step(4'b1001);
    samp = cycle;
    steps(4'b1001, 10);
    check_eq("t5_rise0_latency", 32'(obs_rise[0] - samp), 32'(7));
    check_eq("t5_rise3_latency", 32'(obs_rise[3] - samp), 32'(7));

    // 6: long hold then short hold on channel 1
    steps(4'b0000, 12);
    clear_obs();
    steps(4'b0010, 30);
    gap = obs_long[1] - obs_rise[1];
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
    check_eq("t6_long_gap", 32'(gap), 32'(NLONG));
    check_eq("t6_long_count", 32'(n_long[1]), 32'(1));
`else
    check_eq("t6_no_long", 32'(n_long[1]), 32'(0));
`endif
    steps(4'b0000, 12);
    steps(4'b0010, 6);
    steps(4'b0000, 12);
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
    check_eq("t6_short_none", 32'(n_long[1]), 32'(1));
`else
    check_eq("t6_short_none", 32'(n_long[1]), 32'(0));
`endif

    // Random per-channel hold lengths, with one reset in the middle
    rd = '0;
    for (int i = 0; i < NCH; i++) hold_left[i] = int'($urandom_range(1, 14));
    for (int c = 0; c < 600; c++) begin
      if (c == 300) pulse_reset(1);
      for (int i = 0; i < NCH; i++) begin
        hold_left[i]--;
        if (hold_left[i] <= 0) begin
          rd[i]        = ~rd[i];
          hold_left[i] = int'($urandom_range(1, 14));
        end
      end
      step(rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel debouncer for push-buttons and slide switches. It is the successor to the single-channel debouncer. Each channel has an input synchronizer, an independent stability counter, a debounced level, and one-cycle rise/fall pulses, which remove per-channel edge detectors downstream. It sits between the board-level GPIO pins and the control/status logic, in the `clk` domain.

Parameters:
- NCH, 4, number of independent channels (1..32)
- NDELAY, 1000000, cycles the synchronized input must hold stable before the debounced output takes its value
- NBITS, 20, stability counter width; must satisfy 2^NBITS > NDELAY
- SYNC_STAGES, 2, synchronizer flops per channel (2..4)
- INIT, 0, reset level for all channels' synchronizer, candidate and debounced output (single bit, applied to all channels)
- NLONG, 3000000, long-press threshold in cycles (used only with LONG_PRESS_EN)
- LBITS, 22, long-press counter width; must satisfy 2^LBITS > NLONG

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- din  in  NCH  raw asynchronous inputs
- dout  out  NCH  debounced levels
- rise  out  NCH  one-cycle pulse when dout[i] goes 0->1
- fall  out  NCH  one-cycle pulse when dout[i] goes 1->0
- any_change  out  1  registered OR of (rise|fall) over the previous cycle's pulses
- long_press  out  NCH  one-cycle pulse on long hold; tied 0 without LONG_PRESS_EN

Behaviour:
- Reset is asynchronous and active-low; clock is `clk`.
- Reset values:
  - sync chain, candidate and dout: all bits = INIT
  - count: 0
  - rise, fall, any_change, long_press: 0
  - long counters: 0
- Per channel i, all channels evaluated in parallel every cycle:
  - sync chain: SYNC_STAGES flops; s[i] is the last-stage output.
  - If s[i] != cand[i]: cand[i] <= s[i], count[i] <= 0. This takes priority; any glitch restarts the count.
  - Else if count[i] == NDELAY: dout[i] <= cand[i]; count saturates (holds at NDELAY).
  - Else: count[i] <= count[i] + 1.
- Latency from the first clock edge sampling a new stable din[i] to dout[i] updating: SYNC_STAGES + NDELAY + 1 cycles.
- Pulse outputs:
  - rise[i] / fall[i] are registered and asserted in the same cycle dout[i] changes, for exactly 1 cycle.
  - They are never both high.
  - Writing dout with its current value produces no pulse.
- Toggles shorter than NDELAY+1 stable cycles never reach dout and produce no pulses.
- any_change asserts 1 cycle after any rise/fall pulse.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- Counter arithmetic is unsigned; the counter never wraps because of saturation.
- reset_n asserted mid-count: all state returns to reset values immediately. After release, a channel whose din differs from INIT behaves as a fresh transition (full latency, then a pulse).

Optional Feature:
Macro: DEBOUNCE_MULTI_LONG_PRESS_EN
- With the macro:
  - Per-channel LBITS long counter. It clears when dout[i] == 0, and increments while dout[i] == 1 up to NLONG, then saturates.
  - long_press[i] pulses for 1 cycle on the cycle the counter reaches NLONG.
  - One pulse per press; a new pulse requires a release (dout 0) first.
  - A release before NLONG gives no pulse.
- Without the macro: long counters are not built and long_press is constant 0.

Test Plan:
All scenarios use NCH=4, NDELAY=4, NBITS=3, SYNC_STAGES=2, INIT=0, NLONG=10.
1. Reset with din=4'b0000, then din[0] 0->1 held -> dout[0]=1 and rise[0]=1 exactly 7 cycles after the sampling edge; rise is 1 cycle wide; fall=0; any_change=1 the next cycle.
2. din[1] toggles, each level held 3 cycles, for 40 cycles -> dout[1] stays 0; rise/fall never assert.
3. din[0] and din[3] rise on the same edge -> rise=4'b1001 in a single cycle; dout=4'b1001.
4. dout[2]=1 steady, then din[2] drops with a 2-cycle 1-glitch at cycle 3 of the low period -> fall[2] occurs 7 cycles after the last glitch edge; only one fall pulse.
5. reset_n pulsed low at count=2 during a 0->1 transition on din[0], with din held 1 -> outputs return to 0 asynchronously; after release, rise[0] occurs 7 cycles later.
6. With DEBOUNCE_MULTI_LONG_PRESS_EN, din[1] held 1 for 30 cycles -> one long_press[1] pulse 10 cycles after rise[1]. A 6-cycle hold gives none. Without the macro, long_press stays 0.
